spi_master_tx: RTL and testbench

- Upstream SPI master feeding the board-level SPI pass-through and the SPI receive/LED block.
- Serialises bytes from a valid/ready stream onto spi_sck/spi_mosi/spi_cs, MSB first, SPI mode 0.
- Generates a timed active-low device reset pulse on spi_reset on request.
- Runs entirely in the sclk domain; all SPI outputs are registered.

---
 rtl/spi_master_tx.sv | 194 +++++++++++++++++++
 tb/tb_spi_master_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: a one-entry holding buffer feeds an MSB-first shifter,
// with CS setup/hold framing and a timed active-low device reset pulse.
module spi_master_tx #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int RST_CYCLES = 16
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              rst_req,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_cs,
    output logic              spi_reset
);

    // tx_valid/tx_ready: a word moves when both are high at a sclk edge; tx_data and
    // tx_last must be stable while tx_valid is high, and tx_ready never depends on tx_valid.

    localparam int HW      = $clog2(CLK_DIV + 1);
    localparam int BW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD)
                           ? ((CS_SETUP > RST_CYCLES) ? CS_SETUP : RST_CYCLES)
                           : ((CS_HOLD > RST_CYCLES) ? CS_HOLD : RST_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD,
        ST_RST_PULSE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [HW-1:0]     half_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shifted;
    logic              cur_last;

    logic [DATA_W-1:0] buf_data;
    logic              buf_last;
    logic              buf_full;

    logic accept;
    logic setup_done;
    logic half_done;
    logic word_end;
    logic load;

    assign tx_ready = ~buf_full;
    assign busy     = (state != ST_IDLE);
    assign accept   = tx_valid & ~buf_full;
    assign shifted  = shreg << 1;

    always_comb begin
        setup_done = (state == ST_SETUP) && (cnt == CW'(CS_SETUP - 1));
        half_done  = (half_cnt == HW'(CLK_DIV - 1));
        word_end   = (state == ST_SHIFT) && spi_sck && half_done && (bit_cnt == '0);
        load       = buf_full && (setup_done || (state == ST_WAIT) || (word_end && !cur_last));
    end

    // The shifter empties the buffer on the load edge; a new word can land on the same edge.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            buf_last <= 1'b0;
        end else begin
            if (load) begin
                buf_full <= 1'b0;
            end
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
                buf_last <= tx_last;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cur_last  <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_cs    <= 1'b1;
            spi_reset <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rst_req) begin
                        state     <= ST_RST_PULSE;
                        spi_reset <= 1'b0;
                    end else if (buf_full) begin
                        state    <= ST_SETUP;
                        spi_cs   <= 1'b0;
                        spi_mosi <= buf_data[DATA_W-1];
                    end
                end
                ST_SETUP: begin
                    // The setup interval stands in for the first bit's low phase.
                    if (setup_done) begin
                        state    <= ST_SHIFT;
                        cnt      <= '0;
                        half_cnt <= '0;
                        bit_cnt  <= BW'(DATA_W - 1);
                        shreg    <= buf_data;
                        cur_last <= buf_last;
                        spi_mosi <= buf_data[DATA_W-1];
                        spi_sck  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt != '0) begin
                                shreg    <= shifted;
                                spi_mosi <= shifted[DATA_W-1];
                                bit_cnt  <= bit_cnt - BW'(1);
                            end else if (cur_last) begin
                                state <= ST_HOLD;
                                cnt   <= '0;
                            end else if (load) begin
                                bit_cnt  <= BW'(DATA_W - 1);
                                shreg    <= buf_data;
                                cur_last <= buf_last;
                                spi_mosi <= buf_data[DATA_W-1];
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                ST_WAIT: begin
                    if (load) begin
                        state    <= ST_SHIFT;
                        half_cnt <= '0;
                        bit_cnt  <= BW'(DATA_W - 1);
                        shreg    <= buf_data;
                        cur_last <= buf_last;
                        spi_mosi <= buf_data[DATA_W-1];
                    end
                end
                ST_HOLD: begin
                    if (cnt == CW'(CS_HOLD - 1)) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RST_PULSE: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        spi_reset <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a slave-side monitor rebuilds bytes and SCK/CS/reset timing,
// checked against hand-computed vectors; a CLK_DIV=1 instance covers the mid-bit abort.
module tb_spi_master_tx;

    localparam int CLK_DIV = 4;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rst_req = 1'b0;
    logic       busy;
    logic       spi_sck, spi_mosi, spi_cs, spi_reset;

    logic       f_rst = 1'b1;
    logic [7:0] f_tx_data = '0;
    logic       f_tx_last = 1'b0;
    logic       f_tx_valid = 1'b0;
    logic       f_tx_ready;
    logic       f_rst_req = 1'b0;
    logic       f_busy;
    logic       f_spi_sck, f_spi_mosi, f_spi_cs, f_spi_reset;

    always #5 sclk = ~sclk;

    spi_master_tx #(.DATA_W(8), .CLK_DIV(CLK_DIV), .CS_SETUP(2), .CS_HOLD(2), .RST_CYCLES(16)) dut (
        .sclk(sclk), .s_rst(s_rst), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rst_req(rst_req), .busy(busy), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_reset(spi_reset)
    );

    spi_master_tx #(.DATA_W(8), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .RST_CYCLES(16)) dut_fast (
        .sclk(sclk), .s_rst(f_rst), .tx_data(f_tx_data), .tx_last(f_tx_last), .tx_valid(f_tx_valid),
        .tx_ready(f_tx_ready), .rst_req(f_rst_req), .busy(f_busy), .spi_sck(f_spi_sck),
        .spi_mosi(f_spi_mosi), .spi_cs(f_spi_cs), .spi_reset(f_spi_reset)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_byte;
        int         exp_pulses;
        int         exp_setup;
        int         exp_hold;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    int cyc = 0;
    logic prev_sck, prev_cs, prev_mosi, prev_rst;
    logic [7:0] rx_shift;
    int rx_bits, sck_run, n_rise, n_fall, hi_bad, lo_bad;
    int cs_falls, cs_rises, cs_fall_cyc, cs_rise_cyc, first_rise_cyc, last_fall_cyc;
    int sck_cs_bad, rst_run, rst_last, rst_pulses, cs_low_in_rst, rst_rise_cyc;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic got_byte(input logic [7:0] b);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rx_byte: got 0x%02h expected none", b);
        end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (b !== e) begin
                bad++;
                $display("FAIL rx_byte: got 0x%02h expected 0x%02h", b, e);
            end
        end
    endtask

    task automatic mon_reset();
        rx_bits = 0; sck_run = 0; n_rise = 0; n_fall = 0; hi_bad = 0; lo_bad = 0;
        cs_falls = 0; cs_rises = 0; cs_fall_cyc = 0; cs_rise_cyc = 0;
        first_rise_cyc = 0; last_fall_cyc = 0; sck_cs_bad = 0;
        rst_run = 0; rst_last = 0; rst_pulses = 0; cs_low_in_rst = 0; rst_rise_cyc = 0;
        rx_shift = '0;
    endtask

    // One sclk cycle; outputs are sampled at the falling edge, the slave view uses prev_mosi.
    task automatic step();
        @(negedge sclk);
        cyc++;
        if (prev_cs && !spi_cs) begin cs_falls++; cs_fall_cyc = cyc; rx_bits = 0; end
        if (!prev_cs && spi_cs) begin cs_rises++; cs_rise_cyc = cyc; end
        if (spi_sck && spi_cs) sck_cs_bad++;
        if (spi_sck != prev_sck) begin
            if (spi_sck) begin
                if (!spi_cs) begin
                    if (n_rise > 0 && sck_run != CLK_DIV) lo_bad++;
                    n_rise++;
                    if (n_rise == 1) first_rise_cyc = cyc;
                    rx_shift = {rx_shift[6:0], prev_mosi};
                    rx_bits++;
                    if (rx_bits == 8) begin got_byte(rx_shift); rx_bits = 0; end
                end
            end else begin
                n_fall++;
                last_fall_cyc = cyc;
                if (sck_run != CLK_DIV) hi_bad++;
            end
            sck_run = 1;
        end else begin
            sck_run++;
        end
        if (!spi_reset) begin
            rst_run++;
            if (!spi_cs) cs_low_in_rst++;
        end else if (!prev_rst) begin
            rst_last = rst_run; rst_pulses++; rst_run = 0; rst_rise_cyc = cyc;
        end
        prev_sck = spi_sck; prev_cs = spi_cs; prev_mosi = spi_mosi; prev_rst = spi_reset;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        logic acc, ok;
        ok = 1'b0;
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            acc = tx_ready;
            step();
            if (acc) begin ok = 1'b1; break; end
        end
        tx_valid = 1'b0;
        chk("send_accept", int'(ok), 1);
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy && tx_ready && spi_cs) begin ok = 1'b1; break; end
        end
        chk("wait_idle", int'(ok), 1);
    endtask

    task automatic fast_send(input logic [7:0] d, input logic l);
        logic acc, ok;
        ok = 1'b0;
        f_tx_data = d; f_tx_last = l; f_tx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            acc = f_tx_ready;
            step();
            if (acc) begin ok = 1'b1; break; end
        end
        f_tx_valid = 1'b0;
        chk("fast_accept", int'(ok), 1);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{data: 8'hA5, exp_byte: 8'hA5, exp_pulses: 8, exp_setup: 2, exp_hold: 2};
        vecs[1] = '{data: 8'h00, exp_byte: 8'h00, exp_pulses: 8, exp_setup: 2, exp_hold: 2};
        vecs[2] = '{data: 8'hFF, exp_byte: 8'hFF, exp_pulses: 8, exp_setup: 2, exp_hold: 2};
        vecs[3] = '{data: 8'h6B, exp_byte: 8'h6B, exp_pulses: 8, exp_setup: 2, exp_hold: 2};

        // Reset held for three cycles.
        prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; prev_rst = 1'b1;
        mon_reset();
        for (int i = 0; i < 3; i++) step();
        chk("rst_cs", int'(spi_cs), 1);
        chk("rst_sck", int'(spi_sck), 0);
        chk("rst_mosi", int'(spi_mosi), 0);
        chk("rst_reset", int'(spi_reset), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        s_rst = 1'b0;
        f_rst = 1'b0;
        step();
        mon_reset();

        // Single-byte frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            mon_reset();
            exp_q.push_back(vecs[v].exp_byte);
            send(vecs[v].data, 1'b1);
            wait_idle(300);
            chk("vec_pulses", n_rise, vecs[v].exp_pulses);
            chk("vec_high_width", hi_bad, 0);
            chk("vec_low_width", lo_bad, 0);
            chk("vec_cs_setup", first_rise_cyc - cs_fall_cyc, vecs[v].exp_setup);
            chk("vec_cs_hold", cs_rise_cyc - last_fall_cyc, vecs[v].exp_hold);
            chk("vec_cs_frames", cs_rises, 1);
            chk("vec_sck_cs_high", sck_cs_bad, 0);
            chk("vec_mosi_idle", int'(spi_mosi), 0);
            chk("vec_sb_empty", exp_q.size(), 0);
            step();
            chk("vec_busy_after", int'(busy), 0);
        end

        // Back-to-back frame with the buffer kept full.
        mon_reset();
        exp_q.push_back(8'h3C); exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        send(8'h3C, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b1);
        wait_idle(600);
        chk("b2b_pulses", n_rise, 24);
        chk("b2b_contig", lo_bad, 0);
        chk("b2b_high_width", hi_bad, 0);
        chk("b2b_cs_falls", cs_falls, 1);
        chk("b2b_cs_rises", cs_rises, 1);
        chk("b2b_sb_empty", exp_q.size(), 0);

        // Underrun: CS and SCK held low while the buffer is empty.
        mon_reset();
        exp_q.push_back(8'h81); exp_q.push_back(8'h7E);
        send(8'h81, 1'b0);
        begin
            logic ok;
            int gap_bad;
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (n_fall >= 8) begin ok = 1'b1; break; end
                step();
            end
            chk("under_first_word", int'(ok), 1);
            gap_bad = 0;
            for (int i = 0; i < 50; i++) begin
                step();
                if (spi_cs || spi_sck) gap_bad++;
            end
            chk("under_gap_lines", gap_bad, 0);
            chk("under_gap_ready", int'(tx_ready), 1);
        end
        send(8'h7E, 1'b1);
        wait_idle(300);
        chk("under_pulses", n_rise, 16);
        chk("under_gaps", lo_bad, 1);
        chk("under_cs_falls", cs_falls, 1);
        chk("under_cs_rises", cs_rises, 1);
        chk("under_sb_empty", exp_q.size(), 0);

        // Reset request together with a word in the same IDLE cycle.
        mon_reset();
        exp_q.push_back(8'h5A);
        rst_req = 1'b1;
        send(8'h5A, 1'b1);
        rst_req = 1'b0;
        wait_idle(400);
        chk("rstp_pulses", rst_pulses, 1);
        chk("rstp_width", rst_last, 16);
        chk("rstp_cs_high", cs_low_in_rst, 0);
        chk("rstp_cs_after", int'(cs_fall_cyc > rst_rise_cyc), 1);
        chk("rstp_byte_pulses", n_rise, 8);
        chk("rstp_sb_empty", exp_q.size(), 0);

        // Reset request during SHIFT is ignored.
        mon_reset();
        exp_q.push_back(8'h99);
        send(8'h99, 1'b1);
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (n_rise >= 2) begin ok = 1'b1; break; end
                step();
            end
            chk("shift_reach", int'(ok), 1);
        end
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        wait_idle(300);
        for (int i = 0; i < 20; i++) step();
        chk("ign_pulses", rst_pulses, 0);
        chk("ign_reset_line", int'(spi_reset), 1);
        chk("ign_busy", int'(busy), 0);
        chk("ign_sb_empty", exp_q.size(), 0);

        // Abort mid-bit on the CLK_DIV=1 instance with a word still buffered.
        fast_send(8'hC3, 1'b0);
        fast_send(8'h3C, 1'b1);
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (f_spi_sck && f_busy) begin ok = 1'b1; break; end
                step();
            end
            chk("abort_reach", int'(ok), 1);
        end
        chk("abort_pre_cs", int'(f_spi_cs), 0);
        chk("abort_pre_ready", int'(f_tx_ready), 0);
        f_rst = 1'b1;
        step();
        chk("abort_cs", int'(f_spi_cs), 1);
        chk("abort_sck", int'(f_spi_sck), 0);
        chk("abort_ready", int'(f_tx_ready), 1);
        chk("abort_busy", int'(f_busy), 0);
        chk("abort_mosi", int'(f_spi_mosi), 0);
        f_rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abort_post_cs", int'(f_spi_cs), 1);
        chk("abort_post_busy", int'(f_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
